// File: rtl/mmc_pkg.sv
// Shared types and constants for the matrix-multiply sequencer.
package mmc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int N_DEF       = 32;
  localparam int LANES_DEF   = 4;
  localparam int ACC_W       = 21;
  localparam int MEM_LAT_DEF = 1;

  // Address widths for the default configuration
  localparam int AW_DEF = $clog2(N_DEF * N_DEF);
  localparam int BW_DEF = $clog2(N_DEF * N_DEF / LANES_DEF);

endpackage

// File: rtl/mmc_strobe_pipe.sv
// Delays rd_en by the SRAM read latency and splits the returned datum
// into clear-and-load (first k of a group) or accumulate strobes.
module mmc_strobe_pipe #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic vld_in,
  input  logic first_in,
  output logic mac_clr,
  output logic mac_en
);

  logic [MEM_LAT-1:0] vld_pipe;
  logic [MEM_LAT-1:0] first_pipe;

  // Shift {valid, first_k} one stage per cycle; abort flushes in-flight reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe   <= '0;
      first_pipe <= '0;
    end else if (clr) begin
      vld_pipe   <= '0;
      first_pipe <= '0;
    end else begin
      vld_pipe[0]   <= vld_in;
      first_pipe[0] <= first_in;
      for (int i = 1; i < MEM_LAT; i++) begin
        vld_pipe[i]   <= vld_pipe[i-1];
        first_pipe[i] <= first_pipe[i-1];
      end
    end
  end

  assign mac_clr = vld_pipe[MEM_LAT-1] &  first_pipe[MEM_LAT-1];
  assign mac_en  = vld_pipe[MEM_LAT-1] & ~first_pipe[MEM_LAT-1];

endmodule

// File: rtl/mmc_sched_ctrl.sv
// Sequencer for the four-lane matrix-multiply datapath: issues A/B reads,
// strobes the MACs and drains lane results to C memory.
// Optional build macro MMC_PERF_CNT_EN adds cycle/stall counters.
module mmc_sched_ctrl
  import mmc_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int LANES   = LANES_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  output logic                            busy,
  output logic                            done,
  output logic [$clog2(N*N)-1:0]          addr_a,
  output logic [$clog2(N*N/LANES)-1:0]    addr_b,
  output logic                            rd_en,
  output logic                            mac_clr,
  output logic                            mac_en,
  output logic [$clog2(LANES)-1:0]        lane_sel,
  output logic                            wr_valid,
  output logic [$clog2(N*N)-1:0]          wr_addr,
`ifdef MMC_PERF_CNT_EN
  output logic [31:0]                     cyc_cnt,
  output logic [31:0]                     stall_cnt,
`else
`endif
  input  logic                            wr_ready
);

  localparam int RW = $clog2(N);
  localparam int GW = $clog2(N / LANES);
  localparam int LW = $clog2(LANES);
  localparam logic [1:0] W_LAST = 2'(MEM_LAT);

  state_t         state, nxt;
  logic [RW-1:0]  row, k;
  logic [GW-1:0]  grp;
  logic [LW-1:0]  lane;
  logic [1:0]     wcnt;
  logic           kill;

  // Abort only matters once a job is running
  assign kill = abort && (state != S_IDLE);

  // N, LANES and N/LANES are powers of two, so the address formulas are concatenations
  assign addr_a   = {row, k};
  assign addr_b   = {k, grp};
  assign wr_addr  = {row, grp, lane};
  assign lane_sel = lane;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    nxt      = state;
    rd_en    = 1'b0;
    wr_valid = 1'b0;
    done     = 1'b0;
    busy     = (state != S_IDLE);
    case (state)
      S_IDLE:  if (start && !abort) nxt = S_ISSUE;
      S_ISSUE: begin
        rd_en = 1'b1;
        if (k == '1) nxt = S_WAIT;
      end
      S_WAIT:  if (wcnt == W_LAST) nxt = S_DRAIN;
      S_DRAIN: begin
        wr_valid = 1'b1;
        if (wr_ready && lane == '1)
          nxt = (grp == '1 && row == '1) ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        done = 1'b1;
        nxt  = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
    if (kill) nxt = S_IDLE;
  end

  // Loop counters: k during ISSUE, wcnt during WAIT, lane/grp/row on drain handshakes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0; grp <= '0; k <= '0; lane <= '0; wcnt <= '0;
    end else if (kill) begin
      row <= '0; grp <= '0; k <= '0; lane <= '0; wcnt <= '0;
    end else begin
      case (state)
        S_ISSUE: k <= (k == '1) ? '0 : k + 1'b1;
        S_WAIT:  wcnt <= (wcnt == W_LAST) ? '0 : wcnt + 1'b1;
        S_DRAIN: begin
          if (wr_ready) begin
            if (lane == '1) begin
              lane <= '0;
              if (grp != '1) begin
                grp <= grp + 1'b1;
              end else begin
                grp <= '0;
                row <= (row == '1) ? '0 : row + 1'b1;
              end
            end else begin
              lane <= lane + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  mmc_strobe_pipe #(.MEM_LAT(MEM_LAT)) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .clr      (kill),
    .vld_in   (rd_en),
    .first_in (k == '0),
    .mac_clr  (mac_clr),
    .mac_en   (mac_en)
  );

`ifdef MMC_PERF_CNT_EN
  // Cycle/stall counters: cleared when a job is accepted, frozen while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (start && !abort) begin
        cyc_cnt   <= '0;
        stall_cnt <= '0;
      end
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (state == S_DRAIN && !wr_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  // Performance counters are not built in this configuration
`endif

endmodule

// File: tb/tb_mmc_sched_ctrl.sv
// Bench for mmc_sched_ctrl: directed vector table, backpressure/abort/reset
// sequences, and a randomized run against a reference model.
module tb_mmc_sched_ctrl;

  localparam int N      = 32;
  localparam int LANES  = 4;
  localparam int ML     = 1;
  localparam int GPR    = N / LANES;
  localparam int GROUPS = N * N / LANES;
  localparam int GCOST  = N + ML + 1 + LANES;

  logic       clk = 1'b0;
  logic       rst, start, abort, wr_ready;
  logic       busy, done, rd_en, mac_clr, mac_en, wr_valid;
  logic [9:0] addr_a, wr_addr;
  logic [7:0] addr_b;
  logic [1:0] lane_sel;
`ifdef MMC_PERF_CNT_EN
  logic [31:0] cyc_cnt, stall_cnt;
`endif

  mmc_sched_ctrl #(.N(N), .LANES(LANES), .MEM_LAT(ML)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .rd_en     (rd_en),
    .mac_clr   (mac_clr),
    .mac_en    (mac_en),
    .lane_sel  (lane_sel),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
`ifdef MMC_PERF_CNT_EN
    .cyc_cnt   (cyc_cnt),
    .stall_cnt (stall_cnt),
`endif
    .wr_ready  (wr_ready)
  );

  always #5 clk = ~clk;

  int n_chk, n_err, tcyc;

  // Reference model state: reads/writes are just running indices into the job
  bit mon_en, m_run;
  int m_cyc, m_rd, m_wr, m_stall, m_prev_rd, m_prev_first;

  typedef struct {
    int cyc; int rd; int a; int b; int clr; int en;
    int wv; int wa; int ls; int dn; int bz;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, tcyc);
    end
  endtask

  function automatic vec_t mk(int cyc, int rd, int a, int b, int clr, int en,
                              int wv, int wa, int ls, int dn, int bz);
    vec_t v;
    v.cyc = cyc; v.rd = rd; v.a = a; v.b = b; v.clr = clr; v.en = en;
    v.wv = wv; v.wa = wa; v.ls = ls; v.dn = dn; v.bz = bz;
    return v;
  endfunction

  // Model step, evaluated on current outputs and the inputs about to be sampled.
  // Read j of the job is (group j/N, k j%N); write w goes to address w.
  task automatic model_step();
    int g, kk, r, p;
    if (!mon_en) begin
      m_run = 0;
      return;
    end
    if (!m_run) begin
      if (start && !abort) begin
        m_run = 1; m_cyc = 0; m_rd = 0; m_wr = 0; m_stall = 0;
        m_prev_rd = 0; m_prev_first = 0;
      end
      return;
    end
    m_cyc++;
    chk("m_busy", busy, 1);
    chk("m_mac_clr", mac_clr, m_prev_rd && m_prev_first);
    chk("m_mac_en", mac_en, m_prev_rd && !m_prev_first);
    m_prev_rd    = rd_en;
    m_prev_first = 0;
    if (rd_en) begin
      g  = m_rd / N;
      kk = m_rd % N;
      r  = g / GPR;
      p  = g % GPR;
      chk("m_addr_a", addr_a, r * N + kk);
      chk("m_addr_b", addr_b, kk * GPR + p);
      m_prev_first = (kk == 0);
      m_rd++;
    end
    if (wr_valid) begin
      chk("m_wr_addr", wr_addr, m_wr);
      chk("m_lane_sel", lane_sel, m_wr % LANES);
      if (wr_ready) m_wr++;
      else          m_stall++;
    end
    if (done) begin
      chk("m_done_cycle", m_cyc, GROUPS * GCOST + m_stall + 1);
      chk("m_writes", m_wr, N * N);
      chk("m_reads", m_rd, GROUPS * N);
      m_run = 0;
    end
  endtask

  // Drive inputs for the next edge, run the model, advance to the next negedge
  task automatic cycle(input bit rdy, input bit st, input bit ab);
    wr_ready = rdy;
    start    = st;
    abort    = ab;
    model_step();
    @(negedge clk);
    tcyc++;
  endtask

  initial begin
    int done_at;
    n_chk = 0; n_err = 0; tcyc = 0; mon_en = 0; m_run = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; wr_ready = 1'b0;

    tbl[0]  = mk(1,    1, 0,  0,   0, 0, 0, 0,    0, 0, 1);
    tbl[1]  = mk(2,    1, 1,  8,   1, 0, 0, 0,    0, 0, 1);
    tbl[2]  = mk(3,    1, 2,  16,  0, 1, 0, 0,    0, 0, 1);
    tbl[3]  = mk(32,   1, 31, 248, 0, 1, 0, 0,    0, 0, 1);
    tbl[4]  = mk(33,   0, 0,  0,   0, 1, 0, 0,    0, 0, 1);
    tbl[5]  = mk(34,   0, 0,  0,   0, 0, 0, 0,    0, 0, 1);
    tbl[6]  = mk(35,   0, 0,  0,   0, 0, 1, 0,    0, 0, 1);
    tbl[7]  = mk(36,   0, 0,  0,   0, 0, 1, 1,    1, 0, 1);
    tbl[8]  = mk(37,   0, 0,  0,   0, 0, 1, 2,    2, 0, 1);
    tbl[9]  = mk(38,   0, 0,  0,   0, 0, 1, 3,    3, 0, 1);
    tbl[10] = mk(39,   1, 0,  1,   0, 0, 0, 0,    0, 0, 1);
    tbl[11] = mk(40,   1, 1,  9,   1, 0, 0, 0,    0, 0, 1);
    tbl[12] = mk(73,   0, 0,  0,   0, 0, 1, 4,    0, 0, 1);
    tbl[13] = mk(76,   0, 0,  0,   0, 0, 1, 7,    3, 0, 1);
    tbl[14] = mk(305,  1, 32, 0,   0, 0, 0, 0,    0, 0, 1);
    tbl[15] = mk(306,  1, 33, 8,   1, 0, 0, 0,    0, 0, 1);
    tbl[16] = mk(339,  0, 0,  0,   0, 0, 1, 32,   0, 0, 1);
    tbl[17] = mk(342,  0, 0,  0,   0, 0, 1, 35,   3, 0, 1);
    tbl[18] = mk(9728, 0, 0,  0,   0, 0, 1, 1023, 3, 0, 1);
    tbl[19] = mk(9729, 0, 0,  0,   0, 0, 0, 0,    0, 1, 1);
    tbl[20] = mk(9730, 0, 0,  0,   0, 0, 0, 0,    0, 0, 0);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_mac", {mac_clr, mac_en}, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_addrs", {addr_a, addr_b, wr_addr, lane_sel}, 0);
    rst = 1'b0;
    cycle(1, 0, 0);
    chk("idle_busy", busy, 0);

    // Baseline full run against the vector table (model runs alongside)
    mon_en = 1;
    tcyc = 0;
    cycle(1, 1, 0);
    for (int i = 0; i < NV; i++) begin
      while (tcyc < tbl[i].cyc) cycle(1, 0, 0);
      chk($sformatf("vec%0d_rd_en", tbl[i].cyc), rd_en, tbl[i].rd);
      chk($sformatf("vec%0d_mac_clr", tbl[i].cyc), mac_clr, tbl[i].clr);
      chk($sformatf("vec%0d_mac_en", tbl[i].cyc), mac_en, tbl[i].en);
      chk($sformatf("vec%0d_wr_valid", tbl[i].cyc), wr_valid, tbl[i].wv);
      chk($sformatf("vec%0d_done", tbl[i].cyc), done, tbl[i].dn);
      chk($sformatf("vec%0d_busy", tbl[i].cyc), busy, tbl[i].bz);
      if (tbl[i].rd != 0) begin
        chk($sformatf("vec%0d_addr_a", tbl[i].cyc), addr_a, tbl[i].a);
        chk($sformatf("vec%0d_addr_b", tbl[i].cyc), addr_b, tbl[i].b);
      end
      if (tbl[i].wv != 0) begin
        chk($sformatf("vec%0d_wr_addr", tbl[i].cyc), wr_addr, tbl[i].wa);
        chk($sformatf("vec%0d_lane_sel", tbl[i].cyc), lane_sel, tbl[i].ls);
      end
    end

    // Backpressure: wr_ready low for 5 cycles while lane 2 of group 0 is offered
    cycle(1, 0, 0);
    tcyc = 0;
    done_at = -1;
    cycle(1, 1, 0);
    while (done_at < 0 && tcyc < 12000) begin
      if (tcyc >= 37 && tcyc <= 42) begin
        chk("bp_wr_valid", wr_valid, 1);
        chk("bp_wr_addr", wr_addr, 2);
        chk("bp_lane_sel", lane_sel, 2);
      end
      if (tcyc == 43) chk("bp_next_addr", wr_addr, 3);
      if (done) done_at = tcyc;
      else      cycle(!(tcyc >= 37 && tcyc <= 41), 0, 0);
    end
    chk("bp_done_cycle", done_at, GROUPS * GCOST + 1 + 5);
    cycle(1, 0, 0);
    chk("bp_busy_after", busy, 0);
    chk("bp_done_once", done, 0);

    // Randomized wr_ready, with start pulses while busy that must be ignored
    tcyc = 0;
    done_at = -1;
    cycle(1, 1, 0);
    while (done_at < 0 && tcyc < 14000) begin
      if (done) done_at = tcyc;
      else      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 0);
    end
    chk("rnd_done_seen", done_at > 0, 1);
    cycle(1, 0, 0);
    chk("rnd_busy_after", busy, 0);
    chk("rnd_done_once", done, 0);

    // Abort at row 3, group 0, k = 10
    mon_en = 0;
    cycle(1, 0, 0);
    tcyc = 0;
    cycle(1, 1, 0);
    while (tcyc < 923) cycle(1, 0, 0);
    chk("ab_addr_a", addr_a, 106);
    chk("ab_rd_en", rd_en, 1);
    cycle(1, 0, 1);
    chk("ab_busy", busy, 0);
    chk("ab_rd_en_off", rd_en, 0);
    chk("ab_mac_clr", mac_clr, 0);
    chk("ab_mac_en", mac_en, 0);
    chk("ab_done", done, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0);
      chk("ab_quiet", {busy, done, rd_en, wr_valid}, 0);
    end
    cycle(1, 1, 1);
    chk("ab_start_with_abort", busy, 0);
    cycle(1, 0, 0);
    chk("ab_start_with_abort2", busy, 0);

    // Restart after abort begins from the first address
    tcyc = 0;
    cycle(1, 1, 0);
    chk("rs_busy", busy, 1);
    chk("rs_rd_en", rd_en, 1);
    chk("rs_addr_a0", addr_a, 0);
    chk("rs_addr_b0", addr_b, 0);
    cycle(1, 0, 0);
    chk("rs_addr_a1", addr_a, 1);
    chk("rs_addr_b1", addr_b, 8);
    chk("rs_mac_clr", mac_clr, 1);
    while (tcyc < 36) cycle(1, 0, 0);
    chk("rs_drain_valid", wr_valid, 1);
    chk("rs_drain_addr", wr_addr, 1);

    // Asynchronous reset mid-DRAIN: outputs clear before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_wr_valid", wr_valid, 0);
    chk("arst_strobes", {rd_en, mac_clr, mac_en, done}, 0);
    chk("arst_wr_addr", wr_addr, 0);
    chk("arst_lane_sel", lane_sel, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0);
      chk("arst_no_done", {busy, done}, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mmc_sched_ctrl.md
Name: mmc_sched_ctrl

Overview:
Sequencer for the four-lane 32x32 matrix-multiply datapath (four MAC units, 8-bit A elements, 32-bit B words packing four 8-bit columns, 21-bit results).
- Generates A/B SRAM read addresses and MAC clear/enable strobes.
- Drains the four lane results to the C memory through a valid/ready write port.
- Provides a start/busy/done/abort handshake to the host.

Parameters:
N, 32, matrix dimension (square, power of two).
LANES, 4, MAC lanes; also B elements per B word; N % LANES == 0.
MEM_LAT, 1, A/B SRAM read latency in cycles (1..3).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  begin a full N x N multiply; sampled only in IDLE
abort  in  1  synchronous cancel; honoured in any non-IDLE state
busy  out  1  high from the edge that accepts start until return to IDLE
done  out  1  one-cycle pulse after the final C write handshake
addr_a  out  clog2(N*N)  A read address = row*N + k
addr_b  out  clog2(N*N/LANES)  B read address = k*(N/LANES) + grp
rd_en  out  1  A/B read enable; high exactly on cycles issuing a valid address
mac_clr  out  1  clear-and-load: accumulator <= product (first k of a group)
mac_en  out  1  accumulate: accumulator += product
lane_sel  out  clog2(LANES)  lane driven onto the C write data mux
wr_valid  out  1  C write request
wr_addr  out  clog2(N*N)  C address = row*N + grp*LANES + lane_sel
wr_ready  in  1  C memory accepts the write when wr_valid && wr_ready

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters (row, grp, k, lane) 0; strobe pipeline cleared.
- States:
  - IDLE: start=1 -> ISSUE; busy rises on that edge. start is ignored while busy.
  - ISSUE: N cycles, k = 0..N-1.
    - rd_en=1; addr_a and addr_b follow the formulas above.
    - On k==N-1 -> WAIT.
  - WAIT: MEM_LAT+1 cycles: read-latency flush plus one cycle for the accumulator register. Then -> DRAIN with lane=0.
  - DRAIN: wr_valid=1, lane_sel=lane, wr_addr as above.
    - lane advances only on a handshake; wr_addr and lane_sel stay stable while wr_ready=0.
    - On the handshake at lane==LANES-1:
      - if grp < N/LANES-1: grp++ -> ISSUE
      - else if row < N-1: grp=0, row++ -> ISSUE
      - else -> DONE
  - DONE: done=1 for one cycle, busy=0 on exit -> IDLE.
- Strobe timing:
  - rd_en is delayed MEM_LAT cycles through a shift pipeline.
  - mac_en is the delayed copy for k>=1; mac_clr is the delayed copy for k==0.
  - mac_clr and mac_en are mutually exclusive; exactly one is high per returned datum.
- Group cost with wr_ready held high: N + MEM_LAT + 1 + LANES cycles. Default: 38 cycles per group, 256 groups.
- Abort:
  - Next edge -> IDLE; strobe pipeline and counters cleared; busy=0; no done pulse.
  - abort together with start in IDLE: start is ignored.
- Asserting rst mid-operation returns the block to the reset state immediately; no partial done.
- Counters wrap only by explicit reset to 0. No arithmetic overflow is possible at the given widths.

Optional Feature:
MMC_PERF_CNT_EN
- Defined: adds outputs `cyc_cnt` [31:0] and `stall_cnt` [31:0].
  - Both clear on the start-accept edge and hold after done or abort.
  - `cyc_cnt` counts every busy cycle.
  - `stall_cnt` counts DRAIN cycles with wr_ready=0.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mmc_pkg:
  - state enum (IDLE, ISSUE, WAIT, DRAIN, DONE)
  - default constants N_DEF=32, LANES_DEF=4, ACC_W=21
  - address-width helper constants
- One natural sub-module, mmc_strobe_pipe: a MEM_LAT-deep shift register carrying {valid, first_k} and producing mac_en/mac_clr. It is cleared by rst and by abort.

Test Plan:
- Basic sequencing (defaults, wr_ready=1), start pulse at edge E0:
  - cycle after E0: addr_a=0, addr_b=0, rd_en=1; next cycle addr_a=1, addr_b=8.
  - mac_clr one cycle after the first rd_en; 31 mac_en cycles follow.
  - wr_addr 0,1,2,3 with lane_sel 0..3 on consecutive cycles.
- Group/row stepping:
  - second group: addr_b = k*8+1, writes at 4..7.
  - row 1, group 0: addr_a starts at 32, writes at 32..35.
  - final write at address 1023.
- Full run with wr_ready=1: exactly 1024 write handshakes; done pulses once 9728 active cycles after start; busy low the following cycle.
- Backpressure: hold wr_ready=0 for 5 cycles at lane 2 of group 0.
  - wr_addr stays at 2 and lane_sel at 2 throughout.
  - no duplicated or skipped address; done arrives 5 cycles later than the baseline.
- Abort mid-ISSUE (k=10, row 3): next cycle IDLE, busy=0, rd_en/mac_en/mac_clr=0, no done. A following start restarts at addr_a=0.
- Async rst asserted during DRAIN: all outputs 0 immediately, without waiting for a clk edge. start while busy is ignored, confirmed by an unchanged address sequence.
